// File: rtl/ltpi_pkg.sv
// LTPI shared frame definitions.
// Used by the transmit frame generator and the receive-side checker.
package ltpi_pkg;

   localparam int FRAME_LEN     = 16;
   localparam int PAYLOAD_BYTES = FRAME_LEN - 3;

   localparam logic [7:0] COMMA_SYM    = 8'hBC;
   localparam logic [7:0] IDLE_SUBTYPE = 8'h00;
   localparam logic [7:0] CRC_POLY     = 8'h07;

   localparam logic [3:0] LAST_PAY_IDX = 4'(FRAME_LEN - 2);

   typedef enum logic [2:0] {
      IDLE,
      COMMA,
      SUBTYPE,
      PAYLOAD,
      CRC
   } ltpi_tx_state_e;

   typedef logic [8*PAYLOAD_BYTES-1:0] ltpi_payload_t;

   // One byte of CRC-8, MSB first, no reflection, no final XOR.
   function automatic logic [7:0] crc8_byte(
      input logic [7:0] crc,
      input logic [7:0] data
   );
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/ltpi_crc8.sv
// Byte-wide CRC-8 accumulator with synchronous clear and enable.
// Clear takes priority over enable.
module ltpi_crc8
   import ltpi_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] crc
);

   logic [7:0] crc_q;
   logic [7:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = 8'h00;
      end else if (en) begin
         crc_d = crc8_byte(crc_q, data);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q <= 8'h00;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/ltpi_frame_tx.sv
// LTPI transmit frame generator: comma, subtype, 13 payload bytes, CRC-8.
// Symbols are registered one clock behind the state/index registers.
module ltpi_frame_tx
   import ltpi_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          tx_en,
   input  logic          frm_valid,
   input  logic [7:0]    frm_subtype,
   input  logic [103:0]  frm_payload,
   output logic          frm_ready,
   output logic [7:0]    sym_data,
   output logic          sym_k,
   output logic          sym_sof,
   output logic [7:0]    frame_cnt,
   output logic          idle_frame
);

   ltpi_tx_state_e state_q, state_d;
   logic [3:0]     idx_q, idx_d;

   logic [7:0]     sub_q, sub_d;
   ltpi_payload_t  pay_q, pay_d;
   logic           cap_idle_q, cap_idle_d;
   logic           frm_ready_q, frm_ready_d;

   logic [7:0]     sym_data_q, sym_data_d;
   logic           sym_k_q, sym_k_d;
   logic           sym_sof_q, sym_sof_d;
   logic           idle_frame_q, idle_frame_d;
   logic [7:0]     frame_cnt_q, frame_cnt_d;

   logic           crc_clr;
   logic           crc_en;
   logic [7:0]     crc_val;
   logic           enter_comma;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q + 4'd1;
      unique case (state_q)
         IDLE: begin
            idx_d = 4'd0;
            if (tx_en) state_d = COMMA;
         end
         COMMA:   state_d = SUBTYPE;
         SUBTYPE: state_d = PAYLOAD;
         PAYLOAD: begin
            if (idx_q == LAST_PAY_IDX) state_d = CRC;
         end
         CRC: begin
            idx_d   = 4'd0;
            state_d = tx_en ? COMMA : IDLE;
         end
         default: begin
            idx_d   = 4'd0;
            state_d = IDLE;
         end
      endcase
   end

   assign enter_comma = (state_d == COMMA);

   // Frame contents are frozen at comma entry; payload shifts out MSB first.
   always_comb begin
      sub_d       = sub_q;
      pay_d       = pay_q;
      cap_idle_d  = cap_idle_q;
      frm_ready_d = 1'b0;
      if (enter_comma) begin
         frm_ready_d = frm_valid;
         cap_idle_d  = !frm_valid;
         sub_d       = frm_valid ? frm_subtype : IDLE_SUBTYPE;
         pay_d       = frm_valid ? frm_payload : '0;
      end else if (state_q == PAYLOAD) begin
         pay_d = pay_q << 8;
      end
   end

   always_comb begin
      sym_data_d   = 8'h00;
      sym_k_d      = 1'b0;
      sym_sof_d    = 1'b0;
      idle_frame_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      crc_clr      = 1'b0;
      crc_en       = 1'b0;
      unique case (state_q)
         COMMA: begin
            sym_data_d = COMMA_SYM;
            sym_k_d    = 1'b1;
            sym_sof_d  = 1'b1;
            crc_clr    = 1'b1;
         end
         SUBTYPE: begin
            sym_data_d = sub_q;
            crc_en     = 1'b1;
         end
         PAYLOAD: begin
            sym_data_d = pay_q[8*PAYLOAD_BYTES-1 -: 8];
            crc_en     = 1'b1;
         end
         CRC: begin
            sym_data_d  = crc_val;
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
         default: begin
            sym_data_d = 8'h00;
         end
      endcase
      if (state_q != IDLE) idle_frame_d = cap_idle_q;
   end

   ltpi_crc8 u_crc (
      .clk   (clk),
      .reset (reset),
      .clr   (crc_clr),
      .en    (crc_en),
      .data  (sym_data_d),
      .crc   (crc_val)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sub_q        <= 8'h00;
         pay_q        <= '0;
         cap_idle_q   <= 1'b0;
         frm_ready_q  <= 1'b0;
         sym_data_q   <= 8'h00;
         sym_k_q      <= 1'b0;
         sym_sof_q    <= 1'b0;
         idle_frame_q <= 1'b0;
         frame_cnt_q  <= 8'h00;
      end else begin
         sub_q        <= sub_d;
         pay_q        <= pay_d;
         cap_idle_q   <= cap_idle_d;
         frm_ready_q  <= frm_ready_d;
         sym_data_q   <= sym_data_d;
         sym_k_q      <= sym_k_d;
         sym_sof_q    <= sym_sof_d;
         idle_frame_q <= idle_frame_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign frm_ready  = frm_ready_q;
   assign sym_data   = sym_data_q;
   assign sym_k      = sym_k_q;
   assign sym_sof    = sym_sof_q;
   assign idle_frame = idle_frame_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ltpi_frame_tx.sv
// Bench for ltpi_frame_tx: randomized frames vs a bit-serial frame model.
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_ltpi_frame_tx;

   logic         clk = 1'b0;
   logic         reset;
   logic         tx_en;
   logic         frm_valid;
   logic [7:0]   frm_subtype;
   logic [103:0] frm_payload;
   logic         frm_ready;
   logic [7:0]   sym_data;
   logic         sym_k;
   logic         sym_sof;
   logic [7:0]   frame_cnt;
   logic         idle_frame;

   ltpi_frame_tx dut (
      .clk         (clk),
      .reset       (reset),
      .tx_en       (tx_en),
      .frm_valid   (frm_valid),
      .frm_subtype (frm_subtype),
      .frm_payload (frm_payload),
      .frm_ready   (frm_ready),
      .sym_data    (sym_data),
      .sym_k       (sym_k),
      .sym_sof     (sym_sof),
      .frame_cnt   (frame_cnt),
      .idle_frame  (idle_frame)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // index 0 of the frame sits in the most significant byte/bit
   logic [127:0] obs_frame;
   logic [15:0]  obs_k, obs_sof, obs_idle, obs_rdy;
   logic [7:0]   cnt_end;
   logic         first_rdy;
   logic [7:0]   first_sym;

   function automatic logic [127:0] model_frame(
      input logic v, input logic [7:0] s, input logic [103:0] p);
      logic [111:0] msg;
      logic [7:0]   crc;
      logic         fb;
      msg = v ? {s, p} : '0;
      crc = 8'h00;
      for (int b = 111; b >= 0; b--) begin
         fb  = crc[7] ^ msg[b];
         crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return {8'hBC, msg, crc};
   endfunction

   function automatic logic [103:0] rand_pay();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[103:0];
   endfunction

   task automatic capture_frame(input int chg_at, input logic nv,
      input logic [7:0] ns, input logic [103:0] np, input logic ntx);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         obs_frame[127-8*i -: 8] = sym_data;
         obs_k[15-i]    = sym_k;
         obs_sof[15-i]  = sym_sof;
         obs_idle[15-i] = idle_frame;
         obs_rdy[15-i]  = frm_ready;
         if (i == chg_at) begin
            frm_valid   = nv;
            frm_subtype = ns;
            frm_payload = np;
            tx_en       = ntx;
         end
      end
      cnt_end = frame_cnt;
   endtask

   task automatic start(input logic v, input logic [7:0] s, input logic [103:0] p);
      @(negedge clk);
      reset = 1'b1;
      tx_en = 1'b0;
      frm_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      tx_en = 1'b1;
      frm_valid = v;
      frm_subtype = s;
      frm_payload = p;
      @(negedge clk);
      first_rdy = frm_ready;
      first_sym = sym_data;
   endtask

   task automatic test_reset();
      logic [127:0] exp;
      reset = 1'b1;
      tx_en = 1'b1;
      frm_valid = 1'b1;
      frm_subtype = 8'hA5;
      frm_payload = rand_pay();
      repeat (3) @(negedge clk);
      n_total++;
      if ({sym_data, sym_k, sym_sof, frame_cnt, idle_frame, frm_ready} !== 20'h0)
         $display("FAIL reset_outputs: got %h %b %b %h %b %b want all zero",
                  sym_data, sym_k, sym_sof, frame_cnt, idle_frame, frm_ready);
      else n_pass++;
      reset = 1'b0;
      frm_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({frm_ready, sym_sof, sym_data} !== 10'h0)
         $display("FAIL reset_latency: got rdy=%b sof=%b data=%h want 0 0 00",
                  frm_ready, sym_sof, sym_data);
      else n_pass++;
      capture_frame(-1, 1'b0, 8'h00, '0, 1'b1);
      exp = model_frame(1'b0, 8'h00, '0);
      n_total++;
      if (obs_frame !== exp) $display("FAIL idle_symbols: got %h want %h", obs_frame, exp);
      else n_pass++;
      n_total++;
      if (obs_k !== 16'h8000) $display("FAIL idle_k: got %h want 8000", obs_k);
      else n_pass++;
      n_total++;
      if (obs_sof !== 16'h8000) $display("FAIL idle_sof: got %h want 8000", obs_sof);
      else n_pass++;
      n_total++;
      if (obs_idle !== 16'hFFFF) $display("FAIL idle_flag: got %h want ffff", obs_idle);
      else n_pass++;
      n_total++;
      if (obs_rdy !== 16'h0) $display("FAIL idle_ready: got %h want 0000", obs_rdy);
      else n_pass++;
      n_total++;
      if (cnt_end !== 8'd1) $display("FAIL idle_cnt: got %0d want 1", cnt_end);
      else n_pass++;
   endtask

   task automatic test_valid_frame();
      logic [127:0] exp;
      logic [7:0]   s;
      logic [103:0] p;
      logic         v;
      for (int n = 0; n < 4; n++) begin
         if (n == 0) begin
            v = 1'b1;
            s = 8'h05;
            p = 104'h0102030405060708090A0B0C0D;
         end else begin
            v = 1'($urandom_range(0, 1));
            s = 8'($urandom);
            p = rand_pay();
         end
         start(v, s, p);
         n_total++;
         if (first_rdy !== v) $display("FAIL valid_ready_pulse: got %b want %b", first_rdy, v);
         else n_pass++;
         capture_frame(-1, 1'b0, 8'h00, '0, 1'b1);
         exp = model_frame(v, s, p);
         n_total++;
         if (obs_frame !== exp) $display("FAIL valid_symbols: got %h want %h", obs_frame, exp);
         else n_pass++;
         n_total++;
         if ({obs_k, obs_sof} !== 32'h80008000)
            $display("FAIL valid_k_sof: got %h %h want 8000 8000", obs_k, obs_sof);
         else n_pass++;
         n_total++;
         if (obs_idle !== (v ? 16'h0 : 16'hFFFF))
            $display("FAIL valid_idle_flag: got %h want %h", obs_idle, v ? 16'h0 : 16'hFFFF);
         else n_pass++;
         n_total++;
         if (obs_rdy !== {15'h0, v}) $display("FAIL valid_ready_window: got %h want %h", obs_rdy, {15'h0, v});
         else n_pass++;
      end
   endtask

   task automatic test_hold_change();
      logic [7:0]   sa, sb;
      logic [103:0] pa, pb;
      logic [127:0] exp;
      sa = 8'($urandom);
      sb = 8'($urandom);
      pa = rand_pay();
      pb = rand_pay();
      start(1'b1, sa, pa);
      capture_frame(7, 1'b1, sb, pb, 1'b1);
      exp = model_frame(1'b1, sa, pa);
      n_total++;
      if (obs_frame !== exp) $display("FAIL hold_inflight: got %h want %h", obs_frame, exp);
      else n_pass++;
      n_total++;
      if (obs_rdy !== 16'h0001) $display("FAIL hold_ready: got %h want 0001", obs_rdy);
      else n_pass++;
      capture_frame(-1, 1'b1, sb, pb, 1'b1);
      exp = model_frame(1'b1, sb, pb);
      n_total++;
      if (obs_frame !== exp) $display("FAIL hold_next_frame: got %h want %h", obs_frame, exp);
      else n_pass++;
      n_total++;
      if (obs_sof !== 16'h8000) $display("FAIL back_to_back_sof: got %h want 8000", obs_sof);
      else n_pass++;
      n_total++;
      if (cnt_end !== 8'd2) $display("FAIL back_to_back_cnt: got %0d want 2", cnt_end);
      else n_pass++;
   endtask

   task automatic test_tx_drop();
      logic [7:0]   sa, sc;
      logic [103:0] pa, pc;
      logic [127:0] exp;
      logic         v;
      int           bad;
      v  = 1'($urandom_range(0, 1));
      sa = 8'($urandom);
      sc = 8'($urandom);
      pa = rand_pay();
      pc = rand_pay();
      start(v, sa, pa);
      capture_frame(5, v, sa, pa, 1'b0);
      exp = model_frame(v, sa, pa);
      n_total++;
      if (obs_frame !== exp) $display("FAIL drop_completes: got %h want %h", obs_frame, exp);
      else n_pass++;
      n_total++;
      if (obs_rdy !== 16'h0) $display("FAIL drop_ready: got %h want 0000", obs_rdy);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if ({sym_data, sym_k, sym_sof, idle_frame, frm_ready} !== 12'h0) bad++;
         if (frame_cnt !== 8'd1) bad++;
      end
      n_total++;
      if (bad !== 0) $display("FAIL drop_idle_quiet: got %0d bad samples want 0", bad);
      else n_pass++;
      tx_en = 1'b1;
      frm_valid = 1'b1;
      frm_subtype = sc;
      frm_payload = pc;
      @(negedge clk);
      n_total++;
      if ({frm_ready, sym_data} !== 9'h100)
         $display("FAIL drop_resume_ready: got rdy=%b data=%h want 1 00", frm_ready, sym_data);
      else n_pass++;
      capture_frame(-1, 1'b0, 8'h00, '0, 1'b1);
      exp = model_frame(1'b1, sc, pc);
      n_total++;
      if (obs_frame !== exp) $display("FAIL drop_resume_frame: got %h want %h", obs_frame, exp);
      else n_pass++;
      n_total++;
      if (cnt_end !== 8'd2) $display("FAIL drop_resume_cnt: got %0d want 2", cnt_end);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0]   sa, sd;
      logic [103:0] pa, pd;
      logic [127:0] exp;
      sa = 8'($urandom);
      sd = 8'($urandom);
      pa = rand_pay();
      pd = rand_pay();
      start(1'b1, sa, pa);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            n_total++;
            if (sym_sof !== 1'b1) $display("FAIL mid_comma: got sof=%b want 1", sym_sof);
            else n_pass++;
         end
      end
      reset = 1'b1;
      tx_en = 1'b1;
      @(negedge clk);
      n_total++;
      if ({sym_data, sym_k, sym_sof, frame_cnt, idle_frame, frm_ready} !== 20'h0)
         $display("FAIL mid_reset_outputs: got %h %b %b %h %b %b want all zero",
                  sym_data, sym_k, sym_sof, frame_cnt, idle_frame, frm_ready);
      else n_pass++;
      reset = 1'b0;
      frm_subtype = sd;
      frm_payload = pd;
      @(negedge clk);
      n_total++;
      if (frm_ready !== 1'b1) $display("FAIL mid_restart_ready: got %b want 1", frm_ready);
      else n_pass++;
      capture_frame(-1, 1'b1, sd, pd, 1'b1);
      exp = model_frame(1'b1, sd, pd);
      n_total++;
      if (obs_frame !== exp) $display("FAIL mid_restart_frame: got %h want %h", obs_frame, exp);
      else n_pass++;
      n_total++;
      if (cnt_end !== 8'd1) $display("FAIL mid_restart_cnt: got %0d want 1", cnt_end);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic         v, nv;
      logic [7:0]   s, ns;
      logic [103:0] p, np;
      logic [127:0] exp;
      v = 1'($urandom_range(0, 1));
      s = 8'($urandom);
      p = rand_pay();
      start(v, s, p);
      for (int f = 0; f < 256; f++) begin
         nv = 1'($urandom_range(0, 1));
         ns = 8'($urandom);
         np = rand_pay();
         capture_frame(14, nv, ns, np, 1'b1);
         exp = model_frame(v, s, p);
         n_total++;
         if (obs_frame !== exp || obs_k !== 16'h8000 || obs_sof !== 16'h8000 ||
             obs_idle !== (v ? 16'h0 : 16'hFFFF) || obs_rdy !== {15'h0, nv})
            $display("FAIL wrap_frame %0d: got %h k=%h sof=%h idle=%h rdy=%h want %h",
                     f, obs_frame, obs_k, obs_sof, obs_idle, obs_rdy, exp);
         else n_pass++;
         if (f == 254) begin
            n_total++;
            if (cnt_end !== 8'd255) $display("FAIL wrap_cnt_255: got %0d want 255", cnt_end);
            else n_pass++;
         end
         v = nv;
         s = ns;
         p = np;
      end
      n_total++;
      if (cnt_end !== 8'd0) $display("FAIL wrap_cnt_0: got %0d want 0", cnt_end);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      tx_en = 1'b0;
      frm_valid = 1'b0;
      frm_subtype = 8'h00;
      frm_payload = '0;
      test_reset();
      test_valid_frame();
      test_hold_change();
      test_tx_drop();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
